// File: rtl/product_bcd_converter_if.sv
// Handshake and result bus between the signed multiplier, the BCD converter and the display stage.
// The master drives the load request; the slave returns busy/done and the BCD digits.
interface product_bcd_converter_if #(
  parameter int DW_2 = 8
);
  logic            load;
  logic            sign;
  logic [DW_2-1:0] product;
  logic            busy;
  logic            done;
  logic            bcd_sign;
  logic [3:0]      bcd_hundreds;
  logic [3:0]      bcd_tens;
  logic [3:0]      bcd_units;

  modport master (
    output load, sign, product,
    input  busy, done, bcd_sign, bcd_hundreds, bcd_tens, bcd_units
  );

  modport slave (
    input  load, sign, product,
    output busy, done, bcd_sign, bcd_hundreds, bcd_tens, bcd_units
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Double-dabble binary-to-BCD converter, one bit per clock; done pulses DW_2 cycles after load.
// No backpressure: a load seen while a conversion is running is dropped.
module product_bcd_converter #(
  parameter int DW_2   = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  product_bcd_converter_if.slave  bus
);
  localparam int SW = DIGITS * 4;
  localparam int CW = (DW_2 > 1) ? $clog2(DW_2) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [DW_2-1:0] bin;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   scratch_nxt;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            nz_q;
  logic            last;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Adjusted scratch shifts left, pulling in the next binary MSB.
  assign scratch_nxt = {adj[SW-2:0], bin[DW_2-1]};
  assign last        = (cnt == CW'(DW_2 - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bin              <= '0;
      scratch          <= '0;
      cnt              <= '0;
      sign_q           <= 1'b0;
      nz_q             <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.bcd_sign     <= 1'b0;
      bus.bcd_hundreds <= 4'd0;
      bus.bcd_tens     <= 4'd0;
      bus.bcd_units    <= 4'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin      <= bus.product;
            scratch  <= '0;
            sign_q   <= bus.sign;
            nz_q     <= |bus.product;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          scratch <= scratch_nxt;
          bin     <= {bin[DW_2-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
          if (last) begin
            bus.bcd_hundreds <= scratch_nxt[11:8];
            bus.bcd_tens     <= scratch_nxt[7:4];
            bus.bcd_units    <= scratch_nxt[3:0];
            // A zero magnitude is always displayed as positive.
            bus.bcd_sign     <= sign_q & nz_q;
            bus.done         <= 1'b1;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: hand-computed vectors, load/reset corner cases and a full sweep.
module tb_product_bcd_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  product_bcd_converter_if #(.DW_2(8)) bus ();

  product_bcd_converter #(.DW_2(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] packed_out();
    return {bus.bcd_sign, bus.bcd_hundreds, bus.bcd_tens, bus.bcd_units};
  endfunction

  // Called just after the accepting edge; steps until done (bounded) and reports latency/busy count.
  task automatic wait_done(output int lat, output int bcnt, output int overlap);
    lat = 0;
    bcnt = 0;
    overlap = 0;
    while (lat < 20) begin
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) break;
      step();
      lat++;
    end
  endtask

  task automatic do_conv(input string tag, input logic s, input logic [7:0] p, input logic [12:0] exp);
    int lat, bcnt, overlap;
    bus.load    = 1'b1;
    bus.sign    = s;
    bus.product = p;
    step();
    bus.load    = 1'b0;
    wait_done(lat, bcnt, overlap);
    check({tag, " latency"}, lat, 8);
    check({tag, " busy_cycles"}, bcnt, 8);
    check({tag, " busy_done_overlap"}, overlap, 0);
    check({tag, " digits"}, {19'd0, packed_out()}, {19'd0, exp});
    step();
    check({tag, " done_width"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int lat, bcnt, overlap, ndone;
    logic [12:0] exp;
    bus.load    = 1'b0;
    bus.sign    = 1'b0;
    bus.product = 8'd0;

    step();
    step();
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset digits", {19'd0, packed_out()}, 32'd0);
    rst = 1'b0;
    step();

    do_conv("p105", 1'b0, 8'd105, 13'h0105);
    do_conv("p28n", 1'b1, 8'd28,  13'h1028);
    do_conv("p30n", 1'b1, 8'd30,  13'h1030);
    do_conv("p255", 1'b0, 8'd255, 13'h0255);
    do_conv("negzero", 1'b1, 8'd0, 13'h0000);
    do_conv("p99", 1'b0, 8'd99, 13'h0099);

    // Loads at E3 and E8 must be ignored; a load still high at E9 starts a new conversion.
    bus.load    = 1'b1;
    bus.sign    = 1'b0;
    bus.product = 8'd105;
    step();
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      bus.load    = (k == 3 || k == 8);
      bus.sign    = (k == 3);
      bus.product = 8'd200;
      step();
      if (bus.done) ndone++;
    end
    check("ignore done_count", ndone, 1);
    check("ignore digits", {19'd0, packed_out()}, 32'h0105);
    check("ignore busy_at_E8", {31'd0, bus.busy}, 32'd0);
    step();
    bus.load = 1'b0;
    check("accept_E9 busy", {31'd0, bus.busy}, 32'd1);
    wait_done(lat, bcnt, overlap);
    check("accept_E9 latency", lat, 8);
    check("accept_E9 digits", {19'd0, packed_out()}, 32'h0200);
    step();

    // Reset mid-conversion clears outputs asynchronously and suppresses done.
    bus.load    = 1'b1;
    bus.sign    = 1'b1;
    bus.product = 8'd255;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #1 rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, bus.busy}, 32'd0);
    check("midrst digits", {19'd0, packed_out()}, 32'd0);
    #1 rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.done) ndone++;
    end
    check("midrst no_done", ndone, 0);
    do_conv("post_rst42", 1'b0, 8'd42, 13'h0042);

    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 256; p++) begin
        exp = {(s == 1) && (p != 0), 4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
        do_conv($sformatf("sweep s%0d p%0d", s, p), s[0], p[7:0], exp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
